// File: rtl/alu_issue_stage_if.sv
// Bundle of the ID->EX handshake, the EX<->ALU operand/result bus and the
// EX->MS result bus. The issue stage uses the slave view; the surrounding
// pipeline (decode, ALU, memory stage) uses the master view.
interface alu_issue_stage_if;

    // Decode -> issue stage
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [31:0] ds_pc;
    logic [31:0] ds_rs_value;
    logic [31:0] ds_rt_value;
    logic [15:0] ds_imm;
    logic [4:0]  ds_sa;
    logic [1:0]  ds_src0_sel;
    logic [1:0]  ds_src1_sel;
    logic [11:0] ds_aluop;
    logic        ds_ov_en;
    logic [4:0]  ds_dest;
    logic        ds_gr_we;

    // Issue stage <-> ALU
    logic [31:0] alu_scr0;
    logic [31:0] alu_scr1;
    logic [11:0] alu_aluop;
    logic [31:0] alu_result;
    logic        alu_overflow;

    // Issue stage -> memory stage
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_ex;
    logic [4:0]  es_excode;
    logic [31:0] es_pc;

    modport slave (
        input  ds_to_es_valid, ds_pc, ds_rs_value, ds_rt_value, ds_imm, ds_sa,
               ds_src0_sel, ds_src1_sel, ds_aluop, ds_ov_en, ds_dest, ds_gr_we,
               alu_result, alu_overflow, ms_allowin,
        output es_allowin, alu_scr0, alu_scr1, alu_aluop,
               es_to_ms_valid, es_result, es_dest, es_gr_we, es_ex, es_excode, es_pc
    );

    modport master (
        output ds_to_es_valid, ds_pc, ds_rs_value, ds_rt_value, ds_imm, ds_sa,
               ds_src0_sel, ds_src1_sel, ds_aluop, ds_ov_en, ds_dest, ds_gr_we,
               alu_result, alu_overflow, ms_allowin,
        input  es_allowin, alu_scr0, alu_scr1, alu_aluop,
               es_to_ms_valid, es_result, es_dest, es_gr_we, es_ex, es_excode, es_pc
    );

endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX pipeline stage: holds one decoded instruction, selects the ALU
// operands, and forwards the ALU result to the memory stage with the GPR
// write enable qualified by the overflow exception.
module alu_issue_stage #(
    parameter logic [4:0] NONE_EXC_CODE = 5'h00,
    parameter logic [4:0] OV_EXC_CODE   = 5'h0c
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    alu_issue_stage_if.slave bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  sa;
        logic [1:0]  src0_sel;
        logic [1:0]  src1_sel;
        logic [11:0] aluop;
        logic        ov_en;
        logic [4:0]  dest;
        logic        gr_we;
    } payload_t;

    logic     es_valid_q, es_valid_d;
    payload_t payload_q, payload_d;
    payload_t payload_in;

    logic        es_ready_go;
    logic        es_allowin;
    logic        es_ex;
    logic        es_gr_we;
    logic [31:0] src0;
    logic [31:0] src1;

    // Single-cycle ALU: the stage can always hand off once it holds a result.
    assign es_ready_go = 1'b1;

    // Gather the decode-stage offer into one payload word.
    always_comb begin
        payload_in.pc       = bus.ds_pc;
        payload_in.rs       = bus.ds_rs_value;
        payload_in.rt       = bus.ds_rt_value;
        payload_in.imm      = bus.ds_imm;
        payload_in.sa       = bus.ds_sa;
        payload_in.src0_sel = bus.ds_src0_sel;
        payload_in.src1_sel = bus.ds_src1_sel;
        payload_in.aluop    = bus.ds_aluop;
        payload_in.ov_en    = bus.ds_ov_en;
        payload_in.dest     = bus.ds_dest;
        payload_in.gr_we    = bus.ds_gr_we;
    end

    // Handshake: accept when empty or when the held result leaves this cycle.
    always_comb begin
        es_allowin         = !es_valid_q || (es_ready_go && bus.ms_allowin);
        bus.es_allowin     = es_allowin;
        bus.es_to_ms_valid = es_valid_q && es_ready_go && !flush;
    end

    // Next state: flush kills both the held and any incoming instruction.
    always_comb begin
        es_valid_d = es_valid_q;
        payload_d  = payload_q;
        if (flush) begin
            es_valid_d = 1'b0;
        end else if (es_allowin) begin
            es_valid_d = bus.ds_to_es_valid;
            if (bus.ds_to_es_valid) begin
                payload_d = payload_in;
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            payload_q  <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            payload_q  <= payload_d;
        end
    end

    // Operand 0 select; encoding 3 is unused and yields zero.
    always_comb begin
        case (payload_q.src0_sel)
            2'd0:    src0 = payload_q.rs;
            2'd1:    src0 = {27'b0, payload_q.sa};
            2'd2:    src0 = payload_q.pc;
            default: src0 = 32'd0;
        endcase
    end

    // Operand 1 select; encoding 3 is the link offset of 8.
    always_comb begin
        case (payload_q.src1_sel)
            2'd0:    src1 = payload_q.rt;
            2'd1:    src1 = {{16{payload_q.imm[15]}}, payload_q.imm};
            2'd2:    src1 = {16'b0, payload_q.imm};
            default: src1 = 32'd8;
        endcase
    end

    // ALU drive; opcode is gated so an empty stage never requests work.
    always_comb begin
        bus.alu_scr0  = src0;
        bus.alu_scr1  = src1;
        bus.alu_aluop = es_valid_q ? payload_q.aluop : 12'b0;
    end

    // Result forwarding; an overflow trap suppresses the GPR write so that
    // decode sees no pending destination for the faulting instruction.
    always_comb begin
        es_ex         = es_valid_q && payload_q.ov_en && bus.alu_overflow;
        es_gr_we      = es_valid_q && payload_q.gr_we && !es_ex;
        bus.es_ex     = es_ex;
        bus.es_excode = es_ex ? OV_EXC_CODE : NONE_EXC_CODE;
        bus.es_gr_we  = es_gr_we;
        bus.es_dest   = es_gr_we ? payload_q.dest : 5'd0;
        bus.es_result = bus.alu_result;
        bus.es_pc     = payload_q.pc;
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a reference ALU closes the loop, a
// behavioural model predicts every output each cycle, and literal checks pin
// the documented example results.
module tb_alu_issue_stage;

    localparam logic [11:0] OP_ADD = 12'h800;
    localparam logic [11:0] OP_OR  = 12'h020;
    localparam logic [11:0] OP_SLL = 12'h008;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  sa;
        logic [1:0]  s0;
        logic [1:0]  s1;
        logic [11:0] op;
        logic        ov_en;
        logic [4:0]  dest;
        logic        we;
    } instr_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic run_check = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cnt_a = 0, cnt_b = 0, cnt_c = 0, cnt_d = 0;

    alu_issue_stage_if bus ();

    alu_issue_stage #(
        .NONE_EXC_CODE(5'h00),
        .OV_EXC_CODE  (5'h0c)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [11:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        if (op[11])     return a + b;
        else if (op[10]) return a - b;
        else if (op[9])  return {31'b0, $signed(a) < $signed(b)};
        else if (op[8])  return {31'b0, a < b};
        else if (op[7])  return a & b;
        else if (op[6])  return ~(a | b);
        else if (op[5])  return a | b;
        else if (op[4])  return a ^ b;
        else if (op[3])  return b << a[4:0];
        else if (op[2])  return b >> a[4:0];
        else if (op[1])  return $unsigned($signed(b) >>> a[4:0]);
        else if (op[0])  return {b[15:0], 16'b0};
        return 32'd0;
    endfunction

    function automatic logic ovf_f(input logic [11:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        logic [31:0] s;
        logic [31:0] d;
        s = a + b;
        d = a - b;
        if (op[11]) return (a[31] == b[31]) && (s[31] != a[31]);
        if (op[10]) return (a[31] != b[31]) && (d[31] != a[31]);
        return 1'b0;
    endfunction

    // Reference ALU driven by whatever the DUT presents.
    always_comb begin
        bus.alu_result   = alu_f(bus.alu_aluop, bus.alu_scr0, bus.alu_scr1);
        bus.alu_overflow = ovf_f(bus.alu_aluop, bus.alu_scr0, bus.alu_scr1);
    end

    // Model: which instruction the stage holds and whether it is live.
    logic   m_valid;
    instr_t m_ins;
    instr_t in_ins;

    always_comb begin
        in_ins.pc    = bus.ds_pc;
        in_ins.rs    = bus.ds_rs_value;
        in_ins.rt    = bus.ds_rt_value;
        in_ins.imm   = bus.ds_imm;
        in_ins.sa    = bus.ds_sa;
        in_ins.s0    = bus.ds_src0_sel;
        in_ins.s1    = bus.ds_src1_sel;
        in_ins.op    = bus.ds_aluop;
        in_ins.ov_en = bus.ds_ov_en;
        in_ins.dest  = bus.ds_dest;
        in_ins.we    = bus.ds_gr_we;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_ins   <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (!m_valid || bus.ms_allowin) begin
            m_valid <= bus.ds_to_es_valid;
            if (bus.ds_to_es_valid) m_ins <= in_ins;
        end
    end

    logic        e_allowin, e_to_ms, e_ex, e_we;
    logic [31:0] e_s0, e_s1, e_res;
    logic [11:0] e_op;
    logic [4:0]  e_dest, e_code;

    always_comb begin
        e_allowin = !m_valid || bus.ms_allowin;
        e_to_ms   = m_valid && !flush;
        e_s0 = (m_ins.s0 == 2'd0) ? m_ins.rs :
               (m_ins.s0 == 2'd1) ? {27'b0, m_ins.sa} :
               (m_ins.s0 == 2'd2) ? m_ins.pc : 32'd0;
        e_s1 = (m_ins.s1 == 2'd0) ? m_ins.rt :
               (m_ins.s1 == 2'd1) ? {{16{m_ins.imm[15]}}, m_ins.imm} :
               (m_ins.s1 == 2'd2) ? {16'b0, m_ins.imm} : 32'd8;
        e_op   = m_valid ? m_ins.op : 12'b0;
        e_res  = alu_f(e_op, e_s0, e_s1);
        e_ex   = m_valid && m_ins.ov_en && ovf_f(e_op, e_s0, e_s1);
        e_code = e_ex ? 5'h0c : 5'h00;
        e_we   = m_valid && m_ins.we && !e_ex;
        e_dest = e_we ? m_ins.dest : 5'd0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus a delivery log by PC.
    always @(negedge clk) begin
        if (run_check) begin
            chk("allowin", bus.es_allowin, e_allowin);
            chk("to_ms_valid", bus.es_to_ms_valid, e_to_ms);
            chk("alu_scr0", bus.alu_scr0, e_s0);
            chk("alu_scr1", bus.alu_scr1, e_s1);
            chk("alu_aluop", bus.alu_aluop, e_op);
            chk("es_result", bus.es_result, e_res);
            chk("es_ex", bus.es_ex, e_ex);
            chk("es_excode", bus.es_excode, e_code);
            chk("es_gr_we", bus.es_gr_we, e_we);
            chk("es_dest", bus.es_dest, e_dest);
            chk("es_pc", bus.es_pc, m_ins.pc);
            if (bus.es_to_ms_valid && bus.ms_allowin) begin
                case (bus.es_pc)
                    32'h100: cnt_a <= cnt_a + 1;
                    32'h104: cnt_b <= cnt_b + 1;
                    32'h200: cnt_c <= cnt_c + 1;
                    32'h204: cnt_d <= cnt_d + 1;
                    default: ;
                endcase
            end
        end
    end

    function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] rs,
                                  input logic [31:0] rt, input logic [15:0] imm,
                                  input logic [4:0] sa, input logic [1:0] s0,
                                  input logic [1:0] s1, input logic [11:0] op,
                                  input logic ov, input logic [4:0] dest, input logic we);
        instr_t i;
        i.pc = pc; i.rs = rs; i.rt = rt; i.imm = imm; i.sa = sa; i.s0 = s0; i.s1 = s1;
        i.op = op; i.ov_en = ov; i.dest = dest; i.we = we;
        return i;
    endfunction

    task automatic drive(input instr_t i, input logic v);
        bus.ds_to_es_valid = v;
        bus.ds_pc = i.pc;          bus.ds_rs_value = i.rs;    bus.ds_rt_value = i.rt;
        bus.ds_imm = i.imm;        bus.ds_sa = i.sa;
        bus.ds_src0_sel = i.s0;    bus.ds_src1_sel = i.s1;
        bus.ds_aluop = i.op;       bus.ds_ov_en = i.ov_en;
        bus.ds_dest = i.dest;      bus.ds_gr_we = i.we;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    instr_t idle;

    initial begin
        idle  = '0;
        reset = 1'b1;
        flush = 1'b0;
        bus.ms_allowin = 1'b1;
        drive(idle, 1'b0);
        cycle();
        run_check = 1'b1;
        cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_allowin", bus.es_allowin, 1);
        chk("rst_to_ms", bus.es_to_ms_valid, 0);
        chk("rst_gr_we", bus.es_gr_we, 0);
        chk("rst_dest", bus.es_dest, 0);
        chk("rst_aluop", bus.alu_aluop, 0);

        // Back-to-back: addiu, add (trap), addu-style add, sll, jal, src0_sel=3.
        drive(mk(32'h10, 32'h10, 0, 16'hFFFF, 0, 2'd0, 2'd1, OP_ADD, 0, 5'd8, 1), 1);
        cycle();
        drive(mk(32'h14, 32'h7FFF_FFFF, 1, 0, 0, 2'd0, 2'd0, OP_ADD, 1, 5'd9, 1), 1);
        @(negedge clk);
        chk("addiu_scr1", bus.alu_scr1, 32'hFFFF_FFFF);
        chk("addiu_res", bus.es_result, 32'h0000_000F);
        chk("addiu_we", bus.es_gr_we, 1);
        chk("addiu_dest", bus.es_dest, 8);
        chk("addiu_ex", bus.es_ex, 0);
        cycle();
        drive(mk(32'h18, 32'h7FFF_FFFF, 1, 0, 0, 2'd0, 2'd0, OP_ADD, 0, 5'd9, 1), 1);
        @(negedge clk);
        chk("add_ov_ex", bus.es_ex, 1);
        chk("add_ov_code", bus.es_excode, 32'h0c);
        chk("add_ov_we", bus.es_gr_we, 0);
        chk("add_ov_dest", bus.es_dest, 0);
        cycle();
        drive(mk(32'h1C, 0, 32'h3, 0, 5'd4, 2'd1, 2'd0, OP_SLL, 0, 5'd10, 1), 1);
        @(negedge clk);
        chk("addu_res", bus.es_result, 32'h8000_0000);
        chk("addu_we", bus.es_gr_we, 1);
        cycle();
        drive(mk(32'hBFC0_0100, 0, 0, 0, 0, 2'd2, 2'd3, OP_ADD, 0, 5'd31, 1), 1);
        @(negedge clk);
        chk("sll_scr0", bus.alu_scr0, 4);
        chk("sll_res", bus.es_result, 32'h30);
        cycle();
        drive(mk(32'h20, 32'h1234, 0, 16'h8001, 0, 2'd3, 2'd2, OP_OR, 0, 5'd2, 1), 1);
        @(negedge clk);
        chk("jal_res", bus.es_result, 32'hBFC0_0108);
        chk("b2b_to_ms", bus.es_to_ms_valid, 1);
        cycle();
        drive(idle, 0);
        @(negedge clk);
        chk("sel3_scr0", bus.alu_scr0, 0);
        chk("zimm_scr1", bus.alu_scr1, 32'h0000_8001);
        cycle();

        // Stall: A held for 3 cycles while B is offered.
        drive(mk(32'h100, 5, 6, 0, 0, 2'd0, 2'd0, OP_ADD, 0, 5'd3, 1), 1);
        cycle();
        bus.ms_allowin = 1'b0;
        drive(mk(32'h104, 1, 2, 0, 0, 2'd0, 2'd0, OP_ADD, 0, 5'd4, 1), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_allowin", bus.es_allowin, 0);
            chk("stall_pc", bus.es_pc, 32'h100);
            chk("stall_res", bus.es_result, 32'hB);
            cycle();
        end
        bus.ms_allowin = 1'b1;
        cycle();
        drive(idle, 0);
        @(negedge clk);
        chk("stall_b_pc", bus.es_pc, 32'h104);
        chk("stall_b_res", bus.es_result, 32'h3);
        cycle();

        // Flush while stalled with an offer pending.
        drive(mk(32'h200, 7, 7, 0, 0, 2'd0, 2'd0, OP_ADD, 0, 5'd5, 1), 1);
        cycle();
        bus.ms_allowin = 1'b0;
        flush = 1'b1;
        drive(mk(32'h204, 9, 9, 0, 0, 2'd0, 2'd0, OP_ADD, 0, 5'd6, 1), 1);
        @(negedge clk);
        chk("flush_to_ms", bus.es_to_ms_valid, 0);
        cycle();
        flush = 1'b0;
        bus.ms_allowin = 1'b1;
        drive(idle, 0);
        @(negedge clk);
        chk("flush_valid", bus.es_to_ms_valid, 0);
        chk("flush_aluop", bus.alu_aluop, 0);
        chk("flush_pc_held", bus.es_pc, 32'h200);
        cycle();

        // Flush on an empty stage drops the offer even with allowin high.
        flush = 1'b1;
        drive(mk(32'h400, 1, 1, 0, 0, 2'd0, 2'd0, OP_ADD, 0, 5'd7, 1), 1);
        cycle();
        flush = 1'b0;
        drive(idle, 0);
        @(negedge clk);
        chk("flush_empty_to_ms", bus.es_to_ms_valid, 0);
        chk("flush_empty_pc", bus.es_pc, 32'h200);
        cycle();

        // Reset during a stall discards the held instruction.
        drive(mk(32'h300, 2, 2, 0, 0, 2'd0, 2'd0, OP_ADD, 0, 5'd8, 1), 1);
        cycle();
        bus.ms_allowin = 1'b0;
        drive(idle, 0);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        bus.ms_allowin = 1'b1;
        @(negedge clk);
        chk("rst_stall_to_ms", bus.es_to_ms_valid, 0);
        chk("rst_stall_pc", bus.es_pc, 0);
        chk("rst_stall_we", bus.es_gr_we, 0);
        cycle();

        chk("deliver_A", cnt_a, 1);
        chk("deliver_B", cnt_b, 1);
        chk("deliver_C", cnt_c, 0);
        chk("deliver_D", cnt_d, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
